// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hardwired zero register,
// same-cycle write-to-read bypass and a sequenced clear engine.
//
// Handshake: Clear_req is sampled at each ph1 rise. It is accepted only in
// IDLE. Busy is registered and stays high for exactly NUM_REGS cycles while
// the sweep zeroes one register per cycle. Writes presented while Busy is
// high are dropped and flagged by a one-cycle registered Write_err pulse.
// Requests made while Busy is high are ignored; they are neither queued nor
// restart the sweep.
module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    ph1,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   Read_register,
  output logic [NRD*DATA_W-1:0]   Read_data,
  input  logic [ADDR_W-1:0]       Write_register,
  input  logic [DATA_W-1:0]       Write_data,
  input  logic                    RegWrite,
  input  logic                    Clear_req,
  output logic                    Busy,
  output logic                    Write_err,
  output logic                    dbg_state
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic                wr_ok;
  logic [ADDR_W-1:0]   ra;

  // An address is usable when it is implemented and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign dbg_state = state;
  assign wr_ok     = RegWrite && (state == IDLE) && addr_ok(Write_register);

  // Clear sequencer: IDLE accepts a request, CLEAR walks ptr once across the array.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      Busy      <= 1'b0;
      Write_err <= 1'b0;
    end else begin
      Write_err <= RegWrite && (state == CLEAR);
      case (state)
        IDLE: begin
          if (Clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
            Busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST_PTR) begin
            state <= IDLE;
            ptr   <= '0;
            Busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep has priority; normal writes only land while idle.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[Write_register] <= Write_data;
    end
  end

  // Combinational read ports with forwarding of a legal same-cycle write.
  always_comb begin
    Read_data = '0;
    ra        = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = Read_register[k*ADDR_W +: ADDR_W];
      if (!addr_ok(ra)) begin
        Read_data[k*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && wr_ok && (Write_register == ra)) begin
        Read_data[k*DATA_W +: DATA_W] = Write_data;
      end else begin
        Read_data[k*DATA_W +: DATA_W] = mem[ra];
      end
    end
  end

endmodule
